decode_stage: RTL
=================

# decode_stage

Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides, a register scoreboard for RAW/WAW hazard stalls, and illegal-instruction flagging. It sits between fetch and execute, replacing the purely combinational decoder, and is parametrised for register count (RV32I/RV32E) and datapath width. Decoded control fields keep the existing encodings: ALU select, ALU ext, ALU input select, write-back select 0=ALU, 1=load, 2=LUI, 3=jump.

## Interface
- XLEN, 32: immediate and PC width (32 or 64); immediates sign-extend from instr[31] to XLEN.
- NREG, 32: architectural registers (32 or 16); any used rs1/rs2/rd ≥ NREG is illegal.
- Clock and reset: single clock `clk`; reset `rst` is asynchronous, active-high.
- clk in 1: clock.
- rst in 1: async active-high reset.
- in_valid in 1: fetch offers instruction.
- in_ready out 1: stage accepts this cycle.
- in_instr in 32: instruction word.
- in_pc in XLEN: instruction PC.
- out_valid out 1: decoded entry held.
- out_ready in 1: execute accepts.
- out_pc out XLEN: PC of the held entry.
- out_rs1, out_rs2, out_rd out 5 each: register fields.
- out_imm out XLEN: immediate.
- out_opcode out 7, out_alu_sel out 3, out_alu_ext out 1, out_alu_input_sel out 1: ALU/opcode controls.
- out_reg_we out 1, out_wb_sel out 2, out_mem_we out 1, out_branch_sel out 3: write-back, store and branch controls.
- out_illegal out 1: entry is an illegal instruction.
- out_mul out 1: M-extension op (0 when the option is compiled out).
- flush in 1: kill the held entry.
- wb_valid in 1, wb_rd in 5: write-back completion; clears the busy bit for wb_rd.

## Operation
- Storage: one entry register (EMPTY/FULL) plus busy[NREG-1:0].
- in_ready = (EMPTY | out_ready) & !hazard & !flush.
- hazard: any used source register (rs1 for all but LUI/AUIPC/JAL; rs2 for ALU_REG/STORE/BRANCH), or rd when reg_we, hits either:
  - busy[r], or
  - the held entry's rd while out_reg_we and out_valid.
  - x0 never hazards.
- Accept (in_valid & in_ready): decode and load the entry; state goes FULL.
- Fire (out_valid & out_ready): if out_reg_we and out_rd≠0 and !out_illegal, set busy[out_rd]. Entry goes EMPTY unless a new accept occurs in the same cycle.
- wb_valid clears busy[wb_rd]. Set and clear of the same index cannot coincide because of the WAW stall; set has priority if they do.
- flush drops the held entry (out_valid=0 next cycle) and blocks accept that cycle. Scoreboard is untouched; killed downstream instructions must still return wb_valid.
- Illegal conditions:
  - unknown opcode;
  - register index ≥ NREG;
  - ALU_REG with funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101};
  - shift-immediate with bad funct7;
  - BRANCH funct3 ∈ {010, 011}.
- Illegal entries have reg_we=0 and mem_we=0.
- Defined-default rule: fields undefined for an opcode are 0, with no latches (wb_sel=0 for non-writing opcodes).

## Timing
- Decode latency: 1 cycle, from accept to out_valid.
- Throughput: 1 per cycle with no hazards.
- Outputs hold stable while out_valid & !out_ready.
- Reset (asynchronous, any time): out_valid=0, busy=0, all out_* fields=0. in_ready is 1 on the first cycle after reset release if in_valid has no hazard.
- Flush and out_ready together: flush wins and no busy bit is set.

## Configuration
- DECODE_M_EXT_EN defined: ALU_REG with funct7=0000001 is legal, out_mul=1, alu_sel=funct3.
- Not defined: that encoding is illegal and out_mul is tied to 0.

## Structure
- Package decode_pkg holds:
  - opcode localparams (LOAD, STORE, ALU_REG, ALU_IMM, LUI, AUIPC, JAL, JALR, BRANCH);
  - wb_sel enum;
  - decoded-entry struct.
- One sub-module, decode_comb: purely combinational field/immediate/legality decode, shared with future stages.
- The scoreboard and entry register live in decode_stage.

## Test plan
- `addi x1,x0,5` (0x00500093), out_ready=1 → out_valid next cycle; imm=5, rd=1, reg_we=1, wb_sel=0; busy[1] set after fire.
- `lw x2,0(x1)` then `add x3,x2,x2` → add stalls (in_ready=0) until wb_valid with wb_rd=2; add appears the cycle after.
- out_ready=0 for 3 cycles with an entry held → outputs stable, in_ready=0; release → both fire.
- Opcode 0x7F → out_illegal=1, reg_we=0, busy unchanged. With NREG=16, `addi x17,x0,1` → illegal.
- flush while FULL → out_valid=0 next cycle, no busy bit set. rst asserted mid-stall → all outputs 0 immediately.
- `mul x5,x6,x7` (0x027302B3) → out_mul=1 with DECODE_M_EXT_EN; out_illegal=1 without it.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, write-back select encoding and the
// decoded-entry record used by the RV32I decode stage and its combinational
// decoder. The optional M extension is controlled by DECODE_M_EXT_EN.
package decode_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LUI  = 2'd2,
        WB_JUMP = 2'd3
    } wb_sel_e;

    // Everything execute needs except the XLEN-wide immediate and PC,
    // which stay outside so the record is independent of XLEN.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] alu_sel;
        logic       alu_ext;
        logic       alu_input_sel;
        logic       reg_we;
        wb_sel_e    wb_sel;
        logic       mem_we;
        logic [2:0] branch_sel;
        logic       illegal;
        logic       mul;
    } dec_entry_t;

    // True when a register index exists in an nreg-entry register file.
    function automatic logic reg_ok(input logic [4:0] idx, input int nreg);
        return int'(idx) < nreg;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I field, immediate and legality
// decode. Unused register fields and undefined controls are driven to 0;
// illegal instructions collapse to a clean trap record (opcode + illegal).
// With DECODE_M_EXT_EN defined, ALU_REG funct7=0000001 decodes as a
// legal M-extension op.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic [31:0]     i_instr,
    output dec_entry_t      o_dec,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [6:0]      w_shift_f7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    dec_entry_t      w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_known;
    logic            w_bad_enc;
    logic            w_bad_reg;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_use_rd;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_funct7 = i_instr[31:25];

    // On a 64-bit datapath shamt has six bits, so instr[25] is not funct7.
    assign w_shift_f7 = (XLEN == 64) ? {i_instr[31:26], 1'b0} : i_instr[31:25];

    // All immediates sign-extend from instr[31] to XLEN.
    assign w_imm_i = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));

    // Opcode decode, register-use tracking and legality in one pass.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_dec         = '0;
        w_imm         = '0;
        w_known       = 1'b1;
        w_bad_enc     = 1'b0;
        w_bad_reg     = 1'b0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_use_rd      = 1'b0;
        w_dec.opcode  = w_opcode;

        case (w_opcode)
            OP_LOAD: begin
                w_use_rs1           = 1'b1;
                w_use_rd            = 1'b1;
                w_imm               = w_imm_i;
                w_dec.alu_input_sel = 1'b1;
                w_dec.reg_we        = 1'b1;
                w_dec.wb_sel        = WB_LOAD;
            end
            OP_STORE: begin
                w_use_rs1           = 1'b1;
                w_use_rs2           = 1'b1;
                w_imm               = w_imm_s;
                w_dec.alu_input_sel = 1'b1;
                w_dec.mem_we        = 1'b1;
            end
            OP_ALU_REG: begin
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
                w_use_rd      = 1'b1;
                w_dec.alu_sel = w_funct3;
                w_dec.reg_we  = 1'b1;
                case (w_funct7)
                    F7_BASE: w_dec.alu_ext = 1'b0;
                    F7_ALT: begin
                        // Only SUB and SRA have an alternate form.
                        w_dec.alu_ext = 1'b1;
                        if (w_funct3 != 3'b000 && w_funct3 != 3'b101) begin
                            w_bad_enc = 1'b1;
                        end
                    end
`ifdef DECODE_M_EXT_EN
                    F7_MUL: w_dec.mul = 1'b1;
`endif
                    default: w_bad_enc = 1'b1;
                endcase
            end
            OP_ALU_IMM: begin
                w_use_rs1           = 1'b1;
                w_use_rd            = 1'b1;
                w_imm               = w_imm_i;
                w_dec.alu_sel       = w_funct3;
                w_dec.alu_input_sel = 1'b1;
                w_dec.reg_we        = 1'b1;
                if (w_funct3 == 3'b001 && w_shift_f7 != F7_BASE) begin
                    w_bad_enc = 1'b1;
                end
                if (w_funct3 == 3'b101) begin
                    if (w_shift_f7 == F7_ALT) begin
                        w_dec.alu_ext = 1'b1;
                    end else if (w_shift_f7 != F7_BASE) begin
                        w_bad_enc = 1'b1;
                    end
                end
            end
            OP_LUI: begin
                w_use_rd     = 1'b1;
                w_imm        = w_imm_u;
                w_dec.reg_we = 1'b1;
                w_dec.wb_sel = WB_LUI;
            end
            OP_AUIPC: begin
                w_use_rd            = 1'b1;
                w_imm               = w_imm_u;
                w_dec.alu_input_sel = 1'b1;
                w_dec.reg_we        = 1'b1;
            end
            OP_JAL: begin
                w_use_rd     = 1'b1;
                w_imm        = w_imm_j;
                w_dec.reg_we = 1'b1;
                w_dec.wb_sel = WB_JUMP;
            end
            OP_JALR: begin
                w_use_rs1           = 1'b1;
                w_use_rd            = 1'b1;
                w_imm               = w_imm_i;
                w_dec.alu_input_sel = 1'b1;
                w_dec.reg_we        = 1'b1;
                w_dec.wb_sel        = WB_JUMP;
            end
            OP_BRANCH: begin
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
                w_imm            = w_imm_b;
                w_dec.branch_sel = w_funct3;
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                    w_bad_enc = 1'b1;
                end
            end
            default: w_known = 1'b0;
        endcase

        w_dec.rs1 = w_use_rs1 ? w_rs1 : 5'd0;
        w_dec.rs2 = w_use_rs2 ? w_rs2 : 5'd0;
        w_dec.rd  = w_use_rd  ? w_rd  : 5'd0;

        w_bad_reg = (w_use_rs1 && !reg_ok(w_rs1, NREG)) ||
                    (w_use_rs2 && !reg_ok(w_rs2, NREG)) ||
                    (w_use_rd  && !reg_ok(w_rd,  NREG));

        // Illegal instructions carry no register, write or immediate side effects.
        if (!w_known || w_bad_enc || w_bad_reg) begin
            w_dec         = '0;
            w_dec.opcode  = w_opcode;
            w_dec.illegal = 1'b1;
            w_imm         = '0;
        end
    end

    assign o_dec = w_dec;
    assign o_imm = w_imm;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute with
// valid/ready on both sides, a busy-bit scoreboard for RAW/WAW stalls,
// flush of the held entry and illegal-instruction flagging.
// DECODE_M_EXT_EN enables decode of M-extension ALU ops.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_alu_sel,
    output logic            out_alu_ext,
    output logic            out_alu_input_sel,
    output logic            out_reg_we,
    output logic [1:0]      out_wb_sel,
    output logic            out_mem_we,
    output logic [2:0]      out_branch_sel,
    output logic            out_illegal,
    output logic            out_mul,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    dec_entry_t      w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_fire;
    logic [NREG-1:0] w_busy_set;
    logic [NREG-1:0] w_busy_clr;

    logic            r_valid;
    dec_entry_t      r_entry;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [NREG-1:0] r_busy;

    decode_comb #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_decode_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    // Stall when a used source, or the destination of a writer, is still
    // owed by an in-flight instruction or by the entry held here. Unused
    // fields decode to x0, which never hazards.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (r_busy[i] && (w_dec.rs1 == 5'(i) || w_dec.rs2 == 5'(i) ||
                              (w_dec.reg_we && w_dec.rd == 5'(i)))) begin
                w_hazard = 1'b1;
            end
        end
        if (r_valid && r_entry.reg_we && r_entry.rd != 5'd0 &&
            (w_dec.rs1 == r_entry.rd || w_dec.rs2 == r_entry.rd ||
             (w_dec.reg_we && w_dec.rd == r_entry.rd))) begin
            w_hazard = 1'b1;
        end
    end

    assign w_in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;
    // A flushed entry never counts as handed to execute.
    assign w_fire     = r_valid && out_ready && !flush;

    // Per-register set on fire of a writing entry, clear on write-back.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        for (int i = 1; i < NREG; i++) begin
            w_busy_set[i] = w_fire && r_entry.reg_we && !r_entry.illegal &&
                            r_entry.rd == 5'(i);
            w_busy_clr[i] = wb_valid && wb_rd == 5'(i);
        end
    end

    // Entry register: load on accept, drop on fire or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_entry <= w_dec;
                r_imm   <= w_imm;
                r_pc    <= in_pc;
            end
        end
    end

    // Scoreboard: set has priority over a coincident clear of the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the busy vector is control state, not storage, so it must be reset.
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign in_ready          = w_in_ready;
    assign out_valid         = r_valid;
    assign out_pc            = r_pc;
    assign out_imm           = r_imm;
    assign out_rs1           = r_entry.rs1;
    assign out_rs2           = r_entry.rs2;
    assign out_rd            = r_entry.rd;
    assign out_opcode        = r_entry.opcode;
    assign out_alu_sel       = r_entry.alu_sel;
    assign out_alu_ext       = r_entry.alu_ext;
    assign out_alu_input_sel = r_entry.alu_input_sel;
    assign out_reg_we        = r_entry.reg_we;
    assign out_wb_sel        = r_entry.wb_sel;
    assign out_mem_we        = r_entry.mem_we;
    assign out_branch_sel    = r_entry.branch_sel;
    assign out_illegal       = r_entry.illegal;
    // The decoder only raises mul when the M extension is compiled in.
    assign out_mul           = r_entry.mul;

endmodule
